// File: rtl/tp_pkg.sv
// Shared definitions for the test pattern generator.
//   - pattern identifiers driven on pattern_id
//   - bouncing-box direction encoding (bit 1 = moving left, bit 0 = moving up)
//   - ceil(log2) helper used to size position buses
//   - full / zero channel constants (sliced to color_depth by the users)
package tp_pkg;

   localparam logic [1:0] PAT_BARS  = 2'd0;
   localparam logic [1:0] PAT_CHECK = 2'd1;
   localparam logic [1:0] PAT_GRAD  = 2'd2;
   localparam logic [1:0] PAT_BOX   = 2'd3;

   typedef enum logic [1:0] {
      RIGHT_DOWN = 2'b00,
      RIGHT_UP   = 2'b01,
      LEFT_DOWN  = 2'b10,
      LEFT_UP    = 2'b11
   } box_dir_t;

   // Channels up to 16 bits wide are supported; users take the low bits.
   localparam logic [15:0] CH_FULL = 16'hFFFF;
   localparam logic [15:0] CH_ZERO = 16'h0000;

   function automatic int clog2_int(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tp_box_bounce.sv
// Bouncing box position for the box pattern.
// The box moves box_step pixels per axis on every frame_tick and reflects
// off the edges of the active area; the two axes bounce independently.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   frame_tick   one-cycle pulse once per frame (inside vertical blanking)
//   bx, by       top-left corner of the box in active-area pixels
module tp_box_bounce
   import tp_pkg::*;
#(
   parameter int vga_width  = 1024,
   parameter int vga_height = 768,
   parameter int box_size   = 64,
   parameter int box_step   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 frame_tick,
   output logic [clog2_int(vga_width)-1:0]      bx,
   output logic [clog2_int(vga_height)-1:0]     by
);

   localparam int XW = clog2_int(vga_width);
   localparam int YW = clog2_int(vga_height);

   // One extra bit so bx+step never wraps before the limit compare.
   localparam logic [XW:0] X_MAX  = (XW+1)'(vga_width - box_size);
   localparam logic [YW:0] Y_MAX  = (YW+1)'(vga_height - box_size);
   localparam logic [XW:0] STEP_X = (XW+1)'(box_step);
   localparam logic [YW:0] STEP_Y = (YW+1)'(box_step);

   box_dir_t          state, state_nx;
   logic [XW-1:0]     bx_nx;
   logic [YW-1:0]     by_nx;
   logic              left_nx, up_nx;
   logic [XW:0]       sum_x, dif_x;
   logic [YW:0]       sum_y, dif_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RIGHT_DOWN;
         bx    <= '0;
         by    <= '0;
      end else begin
         state <= state_nx;
         bx    <= bx_nx;
         by    <= by_nx;
      end
   end

   always_comb begin
      bx_nx    = bx;
      by_nx    = by;
      left_nx  = state[1];
      up_nx    = state[0];
      sum_x    = {1'b0, bx} + STEP_X;
      dif_x    = {1'b0, bx} - STEP_X;
      sum_y    = {1'b0, by} + STEP_Y;
      dif_y    = {1'b0, by} - STEP_Y;

      if (frame_tick) begin
         if (!state[1]) begin
            if (sum_x >= X_MAX) begin
               bx_nx   = X_MAX[XW-1:0];
               left_nx = 1'b1;
            end else begin
               bx_nx   = sum_x[XW-1:0];
            end
         end else begin
            if ({1'b0, bx} <= STEP_X) begin
               bx_nx   = '0;
               left_nx = 1'b0;
            end else begin
               bx_nx   = dif_x[XW-1:0];
            end
         end

         if (!state[0]) begin
            if (sum_y >= Y_MAX) begin
               by_nx = Y_MAX[YW-1:0];
               up_nx = 1'b1;
            end else begin
               by_nx = sum_y[YW-1:0];
            end
         end else begin
            if ({1'b0, by} <= STEP_Y) begin
               by_nx = '0;
               up_nx = 1'b0;
            end else begin
               by_nx = dif_y[YW-1:0];
            end
         end
      end

      state_nx = box_dir_t'({left_nx, up_nx});
   end

endmodule

// File: rtl/testpattern_gen.sv
// Test pattern pixel source for vga_driver.
// Generates colour bars, a checkerboard, a gradient or a bouncing box over a
// grid. Colour is computed for the pixel one column ahead of h_pos and
// registered, so it lines up with the driver's combinational blanking.
// Per-frame state changes only on the rising edge of vga_vs.
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   h_pos, v_pos         driver scan position
//   vga_vs               driver vsync (active high)
//   pattern_next         level request to advance the pattern
//   vga_r/vga_g/vga_b    registered colour to the driver
//   pattern_id           current pattern (0 bars, 1 checker, 2 gradient, 3 box)
//   frame_cnt            frames since reset, wrapping
module testpattern_gen
   import tp_pkg::*;
#(
   parameter int vga_width   = 1024,
   parameter int vga_height  = 768,
   parameter int color_depth = 8,
   parameter int box_size    = 64,
   parameter int box_step    = 4,
   parameter int auto_frames = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [clog2_int(vga_width)-1:0]   h_pos,
   input  logic [clog2_int(vga_height)-1:0]  v_pos,
   input  logic                              vga_vs,
   input  logic                              pattern_next,
   output logic [color_depth-1:0]            vga_r,
   output logic [color_depth-1:0]            vga_g,
   output logic [color_depth-1:0]            vga_b,
   output logic [1:0]                        pattern_id,
   output logic [15:0]                       frame_cnt
);

   localparam int XW = clog2_int(vga_width);
   localparam int YW = clog2_int(vga_height);
   localparam int CD = color_depth;

   localparam logic        AUTO_EN   = (auto_frames > 0);
   localparam logic [15:0] AUTO_LAST = AUTO_EN ? 16'(auto_frames - 1) : 16'd0;

   localparam logic [CD-1:0] FULL = CH_FULL[CD-1:0];
   localparam logic [CD-1:0] ZERO = CH_ZERO[CD-1:0];

   logic          vs_d, pn_d, pending;
   logic [15:0]   auto_cnt;
   logic          frame_tick, press, auto_expire, advance;
   logic [XW-1:0] bx;
   logic [YW-1:0] by;

   assign frame_tick  = vga_vs & ~vs_d;
   assign press       = pattern_next & ~pn_d;
   assign auto_expire = AUTO_EN & frame_tick & (auto_cnt == AUTO_LAST);
   // A press landing on the tick cycle is honoured at that tick; a press and
   // an auto expiry together still advance by one.
   assign advance     = frame_tick & (pending | press | auto_expire);

   tp_box_bounce #(
      .vga_width  (vga_width),
      .vga_height (vga_height),
      .box_size   (box_size),
      .box_step   (box_step)
   ) u_box (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .bx         (bx),
      .by         (by)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d       <= 1'b0;
         pn_d       <= 1'b0;
         pending    <= 1'b0;
         auto_cnt   <= '0;
         pattern_id <= PAT_BARS;
         frame_cnt  <= '0;
      end else begin
         vs_d <= vga_vs;
         pn_d <= pattern_next;
         if (advance) begin
            pattern_id <= pattern_id + 2'd1;
            pending    <= 1'b0;
            auto_cnt   <= '0;
         end else begin
            if (press) pending <= 1'b1;
            if (frame_tick && AUTO_EN) auto_cnt <= auto_cnt + 16'd1;
         end
         if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Pixel one column ahead; h_pos sits at vga_width-1 just before column 0,
   // so the wrap lines up with the first active pixel.
   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic [2:0]       bar_idx;
   logic [XW+CD-1:0] x_ext;
   logic [YW+CD-1:0] y_ext;
   logic             in_box, on_grid;
   logic [CD-1:0]    r_nx, g_nx, b_nx;

   assign x       = h_pos + 1'b1;
   assign y       = v_pos;
   assign bar_idx = x[XW-1 -: 3];
   // Pad below the LSB so the top CD bits exist even for narrow positions.
   assign x_ext   = {x, {CD{1'b0}}};
   assign y_ext   = {y, {CD{1'b0}}};
   assign in_box  = ({1'b0, x} >= {1'b0, bx}) &&
                    ({1'b0, x} <  ({1'b0, bx} + (XW+1)'(box_size))) &&
                    ({1'b0, y} >= {1'b0, by}) &&
                    ({1'b0, y} <  ({1'b0, by} + (YW+1)'(box_size)));
   assign on_grid = (x[4:0] == 5'd0) || (y[4:0] == 5'd0);

   always_comb begin
      r_nx = ZERO;
      g_nx = ZERO;
      b_nx = ZERO;
      case (pattern_id)
         PAT_BARS: begin
            r_nx = bar_idx[1] ? ZERO : FULL;
            g_nx = bar_idx[2] ? ZERO : FULL;
            b_nx = bar_idx[0] ? ZERO : FULL;
         end
         PAT_CHECK: begin
            if (x[5] ^ y[5]) begin
               r_nx = FULL;
               g_nx = FULL;
               b_nx = FULL;
            end
         end
         PAT_GRAD: begin
            r_nx = x_ext[XW+CD-1 -: CD];
            g_nx = y_ext[YW+CD-1 -: CD];
            b_nx = frame_cnt[CD-1:0];
         end
         default: begin
            if (in_box) begin
               r_nx = FULL;
               g_nx = FULL;
               b_nx = FULL;
            end else if (on_grid) begin
               b_nx = FULL;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r <= '0;
         vga_g <= '0;
         vga_b <= '0;
      end else begin
         vga_r <= r_nx;
         vga_g <= g_nx;
         vga_b <= b_nx;
      end
   end

endmodule

// File: tb/tb_testpattern_gen.sv
// Testbench for testpattern_gen: two instances (manual advance only, and
// auto-advance every 3 frames) share one stimulus stream. A reference model
// pushes expected colour / pattern / frame count per cycle into a queue and a
// monitor pops and compares after each clock edge.
module tb_testpattern_gen;
   import tp_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] h_pos = '0;
   logic [9:0] v_pos = '0;
   logic       vga_vs = 1'b0;
   logic       pattern_next = 1'b0;
   logic [7:0] r0, g0, b0, r3, g3, b3;
   logic [1:0] pid0, pid3;
   logic [15:0] fc0, fc3;

   always #5 clk = ~clk;

   testpattern_gen #(.auto_frames(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .h_pos(h_pos), .v_pos(v_pos), .vga_vs(vga_vs),
      .pattern_next(pattern_next), .vga_r(r0), .vga_g(g0), .vga_b(b0),
      .pattern_id(pid0), .frame_cnt(fc0));

   testpattern_gen #(.auto_frames(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .h_pos(h_pos), .v_pos(v_pos), .vga_vs(vga_vs),
      .pattern_next(pattern_next), .vga_r(r3), .vga_g(g3), .vga_b(b3),
      .pattern_id(pid3), .frame_cnt(fc3));

   typedef struct {
      logic [23:0] rgb0;
      logic [23:0] rgb3;
      logic [1:0]  pid0;
      logic [1:0]  pid3;
      logic [15:0] fc;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Reference model state
   int n_ticks = 0;
   int frames = 0;
   int pat[2] = '{0, 0};
   bit pend[2] = '{0, 0};
   int since[2] = '{0, 0};
   int auto_n[2] = '{0, 3};
   bit vs_prev = 0;
   bit pn_prev = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // Box edge position after n moves: a triangle wave between 0 and lim.
   function automatic int tri_pos(input int n, input int step, input int lim);
      int p;
      p = (n * step) % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   function automatic logic [23:0] model_rgb(input int p, input int x, input int y,
                                             input int fr, input int bx, input int by);
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      case (p)
         0: return bars[x / 128];
         1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
         2: return {8'(x / 4), 8'(y / 4), 8'(fr % 256)};
         default: begin
            if (x >= bx && x < bx + 64 && y >= by && y < by + 64) return 24'hFFFFFF;
            if (x % 32 == 0 || y % 32 == 0) return 24'h0000FF;
            return 24'h000000;
         end
      endcase
   endfunction

   task automatic model_reset();
      n_ticks = 0; frames = 0; vs_prev = 0; pn_prev = 0;
      for (int i = 0; i < 2; i++) begin
         pat[i] = 0; pend[i] = 0; since[i] = 0;
      end
   endtask

   task automatic cycle(input int h, input int v, input bit vs, input bit pn);
      exp_t e;
      int x, bxm, bym;
      bit tick, press;
      @(negedge clk);
      rst_n = 1'b1;
      h_pos = 10'(h);
      v_pos = 10'(v);
      vga_vs = vs;
      pattern_next = pn;
      x = (h + 1) % 1024;
      bxm = tri_pos(n_ticks, 4, 960);
      bym = tri_pos(n_ticks, 4, 704);
      e.rgb0 = model_rgb(pat[0], x, v, frames, bxm, bym);
      e.rgb3 = model_rgb(pat[1], x, v, frames, bxm, bym);
      tick = vs && !vs_prev;
      press = pn && !pn_prev;
      for (int i = 0; i < 2; i++) begin
         if (press) pend[i] = 1;
         if (tick) begin
            since[i]++;
            if (pend[i] || (auto_n[i] > 0 && since[i] == auto_n[i])) begin
               pat[i] = (pat[i] + 1) % 4;
               pend[i] = 0;
               since[i] = 0;
            end
         end
      end
      if (tick) begin
         n_ticks++;
         frames++;
      end
      vs_prev = vs;
      pn_prev = pn;
      e.pid0 = 2'(pat[0]);
      e.pid3 = 2'(pat[1]);
      e.fc = 16'(frames);
      q.push_back(e);
   endtask

   // Half of the pixels land around the box so its edges get exercised.
   task automatic rand_pixel(output int h, output int v);
      int bxm, bym;
      if ($urandom_range(1, 0) == 1) begin
         bxm = tri_pos(n_ticks, 4, 960);
         bym = tri_pos(n_ticks, 4, 704);
         h = (bxm + $urandom_range(66, 0) - 3 + 1024) % 1024;
         v = bym + $urandom_range(66, 0) - 2;
         if (v < 0) v = 0;
         if (v > 767) v = 767;
      end else begin
         h = $urandom_range(1023, 0);
         v = $urandom_range(767, 0);
      end
   endtask

   task automatic tick_pair(input bit pn);
      int h, v;
      rand_pixel(h, v);
      cycle(h, v, 1'b1, pn);
      rand_pixel(h, v);
      cycle(h, v, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every clock after reset release produces one output sample.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         check("rgb_manual", {r0, g0, b0}, 32'(e.rgb0));
         check("rgb_auto", {r3, g3, b3}, 32'(e.rgb3));
         check("pattern_manual", 32'(pid0), 32'(e.pid0));
         check("pattern_auto", 32'(pid3), 32'(e.pid3));
         check("frame_cnt", 32'(fc0), 32'(e.fc));
      end
   end

   initial begin
      int h, v;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rgb", {r0, g0, b0}, 32'h0);
      check("reset_pattern", 32'(pid0), 32'd0);
      check("reset_frame", 32'(fc0), 32'd0);

      // Colour bars, including the column-0 wrap
      cycle(1023, 0, 0, 0);
      cycle(127, 0, 0, 0);
      cycle(1022, 0, 0, 0);

      // Two presses inside one frame advance only once, at the vsync rise
      cycle(500, 100, 0, 1);
      cycle(501, 100, 0, 0);
      cycle(502, 100, 0, 1);
      cycle(503, 100, 0, 0);
      settle();
      check("press_waits_for_tick", 32'(pid0), 32'd0);
      cycle(10, 767, 1, 0);
      cycle(11, 767, 0, 0);
      settle();
      check("double_press_one_step", 32'(pid0), 32'd1);

      // Checkerboard edge at x=32
      cycle(30, 0, 0, 0);
      cycle(31, 0, 0, 0);

      // Reach the box pattern, then track the box
      tick_pair(1);
      tick_pair(1);
      while (n_ticks < 20) tick_pair(0);
      settle();
      check("box_x_20", 32'(dut0.bx), 32'd80);
      check("box_y_20", 32'(dut0.by), 32'd80);
      check("box_dir_20", 32'(dut0.u_box.state), 32'(RIGHT_DOWN));
      while (n_ticks < 240) tick_pair(0);
      settle();
      check("box_x_right_edge", 32'(dut0.bx), 32'd960);
      tick_pair(0);
      settle();
      check("box_x_bounce", 32'(dut0.bx), 32'd956);
      check("box_dir_bounce", 32'(dut0.u_box.state), 32'(LEFT_UP));

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         rand_pixel(h, v);
         cycle(h, v, ($urandom % 5) == 0, ($urandom % 12) == 0);
      end

      // Gradient, then reset mid-line
      cycle(5, 5, 0, 0);
      for (int k = 0; k < 4 && pat[0] != 2; k++) begin
         tick_pair(1);
         cycle(6, 6, 0, 0);
      end
      cycle(300, 200, 0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_rgb", {r0, g0, b0}, 32'h0);
      check("async_reset_pattern", 32'(pid0), 32'd0);
      check("async_reset_frame", 32'(fc0), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      cycle(400, 300, 1, 0);
      settle();
      check("tick_on_release", 32'(fc0), 32'd1);

      // Auto advance on the 3rd tick, with a coinciding press
      cycle(0, 0, 0, 0);
      cycle(1, 1, 1, 0);
      cycle(2, 2, 0, 0);
      cycle(3, 3, 1, 1);
      settle();
      check("auto_plus_press_one_step", 32'(pid3), 32'd1);
      cycle(4, 4, 0, 0);
      settle();
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
